// File: rtl/mips_wb_trace.sv
// Writeback trace FIFO for the mips_32 core: captures every non-$0 register
// write with a sequence number and drains it over a valid/ready port.
module mips_wb_trace #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_en,
    input  logic [4:0]    wb_reg,
    input  logic [31:0]   wb_data,
    input  logic [31:0]   wb_pc,
    input  logic          clear,
    output logic          tr_valid,
    input  logic          tr_ready,
    output logic [31:0]   tr_pc,
    output logic [4:0]    tr_reg,
    output logic [31:0]   tr_data,
    output logic [15:0]   tr_seq,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [15:0]   drop_cnt
);
    localparam int EW = 85;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   seq_q, seq_d, drop_q, drop_d;
    logic          ovf_q, ovf_d;
    logic          wb_event, pop, push, drop, wr_en;
    logic [EW-1:0] head;

    always_comb begin
        wb_event = wb_en && (wb_reg != 5'd0);
        pop      = (count_q != '0) && tr_ready;
        push     = wb_event && ((count_q != FULL) || pop);
        drop     = wb_event && (count_q == FULL) && !pop;
        wr_en    = push && !clear;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        seq_d    = seq_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        // Flush wins over any push, pop or drop in the same cycle.
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            seq_d    = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)
                count_d = count_q + (AW+1)'(1);
            else if (pop && !push)
                count_d = count_q - (AW+1)'(1);
            // Dropped events still consume a sequence number so gaps are visible.
            if (wb_event) seq_d = seq_q + 16'd1;
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {wb_pc, wb_reg, wb_data, seq_q};
    end

    // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
    always_comb begin
        tr_valid = (count_q != '0);
        head     = tr_valid ? mem_q[rd_ptr_q] : '0;
        tr_pc    = head[84:53];
        tr_reg   = head[52:48];
        tr_data  = head[47:16];
        tr_seq   = head[15:0];
        count    = count_q;
        overflow = ovf_q;
        drop_cnt = drop_q;
    end
endmodule
